// File: rtl/shift_8x64_feed_pkg.sv
// Shared types and constants for the 8x64 delay-line feeder and the delay line it drives.
package shift_8x64_feed_pkg;

    localparam int WIDTH      = 8;
    localparam int DEPTH      = 64;
    localparam int TAP_STRIDE = 16;
    localparam int CNT_W      = 7;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Bit k is set when count has reached the tap at stage stride*(k+1).
    function automatic logic [3:0] tap_mask(input logic [6:0] count, input logic [6:0] stride);
        logic [3:0] mask;
        logic [8:0] thr;
        thr = {2'b00, stride};
        for (int k = 0; k < 4; k++) begin
            mask[k] = ({2'b00, count} >= thr);
            thr     = thr + {2'b00, stride};
        end
        return mask;
    endfunction

endpackage

// File: rtl/shift_8x64_feed.sv
// Feeds bytes into a DEPTH-stage delay line, tracks fill level/tap validity
// and zero-fills the whole line on a flush request.
module shift_8x64_feed #(
    parameter int WIDTH      = shift_8x64_feed_pkg::WIDTH,
    parameter int DEPTH      = shift_8x64_feed_pkg::DEPTH,
    parameter int TAP_STRIDE = shift_8x64_feed_pkg::TAP_STRIDE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             hold,
    input  logic             flush,
    output logic             shift,
    output logic [WIDTH-1:0] sr_in,
    output logic [6:0]       fill_count,
    output logic [3:0]       tap_valid,
    output logic             busy
);
    import shift_8x64_feed_pkg::*;

    localparam logic [6:0] DEPTH_C  = 7'(DEPTH);
    localparam logic [6:0] STRIDE_C = 7'(TAP_STRIDE);

    state_t           state_r;
    logic             shift_r;
    logic [WIDTH-1:0] sr_in_r;
    logic [6:0]       fill_count_r;
    logic [3:0]       tap_valid_r;
    logic             busy_r;
    logic [6:0]       flush_cnt_r;

    logic             accept_s;
    logic [6:0]       fill_inc_s;

    // Acceptance handshake and next fill level.
    always_comb begin
        in_ready   = 1'b0;
        accept_s   = 1'b0;
        fill_inc_s = fill_count_r + 7'd1;
        if (rst_n && (state_r != ST_FLUSH) && !hold && !flush) begin
            in_ready = 1'b1;
            accept_s = in_valid;
        end else begin
            in_ready = 1'b0;
            accept_s = 1'b0;
        end
    end

    // Control FSM with fill and flush counters; the flush entry edge already
    // issues the first zero shift, so the counter starts at 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_FILL;
            shift_r      <= 1'b0;
            sr_in_r      <= '0;
            fill_count_r <= 7'd0;
            tap_valid_r  <= 4'd0;
            busy_r       <= 1'b0;
            flush_cnt_r  <= 7'd0;
        end else begin
            case (state_r)
                ST_FILL, ST_RUN: begin
                    if (flush) begin
                        state_r      <= ST_FLUSH;
                        busy_r       <= 1'b1;
                        shift_r      <= 1'b1;
                        sr_in_r      <= '0;
                        flush_cnt_r  <= 7'd1;
                        fill_count_r <= 7'd0;
                        tap_valid_r  <= 4'd0;
                    end else if (accept_s) begin
                        shift_r <= 1'b1;
                        sr_in_r <= in_data;
                        if (state_r == ST_FILL) begin
                            fill_count_r <= fill_inc_s;
                            tap_valid_r  <= tap_mask(fill_inc_s, STRIDE_C);
                            if (fill_inc_s == DEPTH_C) begin
                                state_r <= ST_RUN;
                            end else begin
                                state_r <= ST_FILL;
                            end
                        end else begin
                            fill_count_r <= DEPTH_C;
                        end
                    end else begin
                        shift_r <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_r == DEPTH_C) begin
                        state_r     <= ST_FILL;
                        busy_r      <= 1'b0;
                        shift_r     <= 1'b0;
                        flush_cnt_r <= 7'd0;
                    end else begin
                        shift_r     <= 1'b1;
                        sr_in_r     <= '0;
                        flush_cnt_r <= flush_cnt_r + 7'd1;
                    end
                end
                default: begin
                    state_r      <= ST_FILL;
                    shift_r      <= 1'b0;
                    busy_r       <= 1'b0;
                    flush_cnt_r  <= 7'd0;
                    fill_count_r <= 7'd0;
                    tap_valid_r  <= 4'd0;
                end
            endcase
        end
    end

    assign shift      = shift_r;
    assign sr_in      = sr_in_r;
    assign fill_count = fill_count_r;
    assign tap_valid  = tap_valid_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_shift_8x64_feed.sv
// Randomized bench for shift_8x64_feed against a cycle-level behavioural model.
module tb_shift_8x64_feed;

    localparam int DEPTH  = 64;
    localparam int STRIDE = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       hold = 1'b0;
    logic       flush = 1'b0;
    logic       shift;
    logic [7:0] sr_in;
    logic [6:0] fill_count;
    logic [3:0] tap_valid;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: fill level, flush activity, remaining zero shifts, last outputs.
    int         m_fill  = 0;
    bit         m_busy  = 1'b0;
    int         m_zeros = 0;
    bit         m_shift = 1'b0;
    logic [7:0] m_sr    = 8'd0;

    shift_8x64_feed dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .hold       (hold),
        .flush      (flush),
        .shift      (shift),
        .sr_in      (sr_in),
        .fill_count (fill_count),
        .tap_valid  (tap_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_taps(input int fill);
        logic [3:0] t;
        for (int k = 0; k < 4; k++) t[k] = (fill >= STRIDE * (k + 1));
        return t;
    endfunction

    // One clock: drive inputs, check ready, advance the model, check registered outputs.
    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic h, input logic f);
        logic rdy_exp;
        @(negedge clk);
        rst_n = r; in_valid = v; in_data = d; hold = h; flush = f;
        #1;
        rdy_exp = r && !m_busy && !h && !f;
        check_eq("in_ready", 32'(in_ready), 32'(rdy_exp));
        if (!r) begin
            m_fill = 0; m_busy = 1'b0; m_zeros = 0; m_shift = 1'b0; m_sr = 8'd0;
        end else if (m_busy) begin
            if (m_zeros > 0) begin
                m_shift = 1'b1; m_sr = 8'd0; m_zeros--;
            end else begin
                m_busy = 1'b0; m_shift = 1'b0;
            end
        end else if (f) begin
            m_busy = 1'b1; m_fill = 0; m_zeros = DEPTH - 1; m_shift = 1'b1; m_sr = 8'd0;
        end else if (v && rdy_exp) begin
            m_shift = 1'b1; m_sr = d;
            if (m_fill < DEPTH) m_fill++;
        end else begin
            m_shift = 1'b0;
        end
        @(posedge clk);
        #1;
        check_eq("shift",      32'(shift),      32'(m_shift));
        check_eq("sr_in",      32'(sr_in),      32'(m_sr));
        check_eq("fill_count", 32'(fill_count), 32'(m_fill));
        check_eq("tap_valid",  32'(tap_valid),  32'(exp_taps(m_fill)));
        check_eq("busy",       32'(busy),       32'(m_busy));
    endtask

    initial begin
        // Reset.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        check_eq("reset_fill", 32'(fill_count), 32'd0);

        // Stream 0x01..0x40 back to back.
        for (int i = 1; i <= 64; i++) begin
            step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 16) check_eq("tap_at16", 32'(tap_valid), 32'h1);
            if (i == 32) check_eq("tap_at32", 32'(tap_valid), 32'h3);
            if (i == 48) check_eq("tap_at48", 32'(tap_valid), 32'h7);
        end
        check_eq("full_tap", 32'(tap_valid), 32'hF);

        // Ten more in RUN, fill saturated.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
        check_eq("run_fill", 32'(fill_count), 32'd64);

        // Hold for 5 cycles with data pending.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'($urandom), 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Flush with a competing byte, second flush ignored mid-way.
        step(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
        for (int i = 1; i <= 70; i++)
            step(1'b1, 1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0), 1'(i == 30));

        // Reset in the middle of a flush.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i < 20; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // 63 bytes then the 64th.
        for (int i = 0; i < 63; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
        check_eq("fill63", 32'(fill_count), 32'd63);
        check_eq("tap63",  32'(tap_valid),  32'h7);
        step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
        check_eq("tap64",  32'(tap_valid),  32'hF);

        // Random traffic with occasional hold, flush and reset.
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 255) != 0), 1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 99) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
